// File: rtl/instruction_store.sv
// instruction_store: 256x8 synchronous instruction memory with a byte-wide
// program-load port. After reset it zeroes the whole array (CLEAR), then
// either waits for a host to stream a program in (LOAD) or serves fetches (RUN).
// Optional build macro: INSTRUCTION_STORE_CHECKSUM_EN adds a mod-256 running
// sum of accepted program bytes; without it load_checksum reads as 8'h00.
module instruction_store (
  input  logic       oscillator,
  input  logic       reset,
  input  logic [7:0] instruction_address,
  output logic [7:0] instruction,
  input  logic       load_mode,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       cpu_hold,
  output logic [8:0] load_count,
  output logic       load_overflow,
  output logic [7:0] load_checksum
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] clear_cnt_reg;
  logic [7:0] wr_ptr_reg;
  logic [8:0] load_count_reg;
  logic       load_overflow_reg;
  logic       load_ready_reg;
  logic       cpu_hold_reg;
  logic [7:0] instruction_reg;

  // Storage array; no reset so it maps onto block RAM. CLEAR wipes it instead.
  logic [7:0] mem [0:255];

  logic       accept;
  logic       clear_entry;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  // load_ready_reg is high exactly while the FSM sits in LOAD.
  assign accept      = load_ready_reg & load_valid;
  // Leaving RUN for CLEAR restarts all load bookkeeping from zero.
  assign clear_entry = (state_reg == ST_RUN) && (state_next == ST_CLEAR);

  // Next-state decode; load_mode is only looked at once CLEAR has finished.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (clear_cnt_reg == 8'hFF) state_next = load_mode ? ST_LOAD : ST_RUN;
      ST_LOAD:  if (!load_mode) state_next = ST_RUN;
      ST_RUN:   if (load_mode) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // FSM state, clear sweep, write pointer, counters and registered handshake outputs.
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset) begin
      state_reg         <= ST_CLEAR;
      clear_cnt_reg     <= 8'd0;
      wr_ptr_reg        <= 8'd0;
      load_count_reg    <= 9'd0;
      load_overflow_reg <= 1'b0;
      load_ready_reg    <= 1'b0;
      cpu_hold_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      load_ready_reg <= (state_next == ST_LOAD);
      cpu_hold_reg   <= (state_next != ST_RUN);
      // Sweep counter wraps back to 0 after 255, ready for the next CLEAR.
      if (state_reg == ST_CLEAR) clear_cnt_reg <= clear_cnt_reg + 8'd1;
      else                       clear_cnt_reg <= 8'd0;
      if (clear_entry) begin
        wr_ptr_reg        <= 8'd0;
        load_count_reg    <= 9'd0;
        load_overflow_reg <= 1'b0;
      end else if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 8'd1;
        if (load_count_reg != 9'd256) load_count_reg <= load_count_reg + 9'd1;
        if (wr_ptr_reg == 8'hFF) load_overflow_reg <= 1'b1;
      end
    end
  end

  // Single write port shared by the CLEAR sweep and host program bytes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clear_cnt_reg;
    mem_wdata = 8'h00;
    if (state_reg == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (accept) begin
      mem_we    = 1'b1;
      mem_waddr = wr_ptr_reg;
      mem_wdata = load_data;
    end
  end

  // Memory write.
  always_ff @(posedge oscillator) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered fetch; the processor sees zeros (add r0,r0,r0) unless running.
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset)                    instruction_reg <= 8'h00;
    else if (state_next == ST_RUN) instruction_reg <= mem[instruction_address];
    else                           instruction_reg <= 8'h00;
  end

`ifdef INSTRUCTION_STORE_CHECKSUM_EN
  logic [7:0] checksum_reg;

  // Running mod-256 sum of accepted bytes, restarted with each new load.
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset)           checksum_reg <= 8'h00;
    else if (clear_entry) checksum_reg <= 8'h00;
    else if (accept)      checksum_reg <= checksum_reg + load_data;
  end

  assign load_checksum = checksum_reg;
`else
  assign load_checksum = 8'h00;
`endif

  assign instruction   = instruction_reg;
  assign load_ready    = load_ready_reg;
  assign cpu_hold      = cpu_hold_reg;
  assign load_count    = load_count_reg;
  assign load_overflow = load_overflow_reg;

endmodule
